spi_fetch_unit: RTL and testbench
=================================

SPI_FETCH_UNIT -- requirements
Module: spi_fetch_unit

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 1: clk cycles per SPI half-period (legal 1..255).
REQ-002 SHALL provide port clk, input, 1: clock; all logic on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL provide port target_address, input, 24: flash byte address, latched at transaction start.
REQ-005 SHALL provide port start_fetch, input, 1: level request from the CPU fetch stage.
REQ-006 SHALL provide port fetched_data, output, 32: fetched word, little-endian.
REQ-007 SHALL provide port fetch_done, output, 1: word valid and transaction complete.
REQ-008 SHALL provide port cs, output, 1: SPI chip select, active-low.
REQ-009 SHALL provide port sclk, output, 1: SPI clock, mode 0 (idle low).
REQ-010 SHALL provide port mosi, output, 1: SPI data to flash, MSB first.
REQ-011 SHALL provide port miso, input, 1: SPI data from flash.

Function
REQ-012 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, DONE, all registered.
REQ-013 IDLE: when start_fetch=1, SHALL latch target_address, drive cs low and enter CMD on the next edge.
REQ-014 CMD SHALL shift 8 command bits, ADDR 24 address bits, DATA 32 read bits, all MSB first per byte.
REQ-015 Each SPI bit SHALL take 2*CLK_DIV clk cycles: sclk low for CLK_DIV cycles with mosi stable, then sclk high for CLK_DIV cycles.
REQ-016 mosi SHALL change only while sclk is low; miso SHALL be sampled on the clk edge that drives sclk low-to-high.
REQ-017 The first received byte SHALL go to fetched_data[7:0], the second to [15:8], the third to [23:16], the fourth to [31:24].
REQ-018 After the last DATA bit's high half, SHALL enter DONE: cs=1, sclk=0, fetch_done=1, fetched_data updated in the same edge.
REQ-019 fetch_done SHALL rise exactly 1+128*CLK_DIV cycles after the edge sampling start_fetch=1 in IDLE (fast-read builds: 1+144*CLK_DIV).
REQ-020 DONE SHALL hold fetch_done=1 while start_fetch=1; on start_fetch=0 SHALL return to IDLE, with fetch_done=0 from the next edge.
REQ-021 Deassertion of start_fetch during CMD/ADDR/DUMMY/DATA SHALL be ignored; the transaction completes, then DONE lasts one cycle.
REQ-022 Changes on target_address after latch SHALL NOT affect the in-flight transaction.
REQ-023 fetched_data SHALL hold its value outside the DONE-entry edge; partial shifts SHALL use a separate register.
REQ-024 cs SHALL stay low continuously from CMD through the end of DATA; mosi SHALL be 0 outside CMD and ADDR.

Reset
REQ-025 With rst_n=0 at an edge, SHALL set state=IDLE, cs=1, sclk=0, mosi=0, fetch_done=0, fetched_data=0, and clear counters, even mid-transaction.
REQ-026 After rst_n rises, SHALL start no transaction until start_fetch=1 is sampled in IDLE.

Configuration
REQ-027 Macro SPI_FETCH_FAST_READ_EN SHALL, when defined, use command 0x0B and insert 8 DUMMY bits (mosi=0, miso ignored) between ADDR and DATA.
REQ-028 Without SPI_FETCH_FAST_READ_EN, SHALL use command 0x03 and never enter DUMMY.

Verification
REQ-029 CLK_DIV=1, address 0x000004, flash model returns bytes 13 00 00 00 -> mosi bits 0x03,0x00,0x00,0x04; fetched_data=0x00000013; fetch_done rises 129 cycles after start.
REQ-030 CLK_DIV=3, address 0xABCDEF, bytes 78 56 34 12 -> sclk half-period 3 clk; fetched_data=0x12345678; done at cycle 385.
REQ-031 Drop start_fetch at cycle 40 of a fetch -> transaction completes; fetch_done high exactly 1 cycle; cs high; back in IDLE.
REQ-032 rst_n=0 at cycle 60 of a fetch -> next edge cs=1, sclk=0, fetch_done=0, fetched_data=0; new fetch after release is bit-exact.
REQ-033 Hold start_fetch high 10 cycles after done, then drop -> fetch_done high 10 cycles, low 1 cycle after drop; no second cs assertion.
REQ-034 SPI_FETCH_FAST_READ_EN defined, address 0x000100 -> command 0x0B, 8 dummy sclk cycles, done at cycle 145 (CLK_DIV=1).

Source files
------------

// File: rtl/spi_fetch_unit.sv
// spi_fetch_unit
//   Fetches one 32-bit little-endian word from a SPI NOR flash (mode 0,
//   MSB first) for the CPU fetch stage. A transaction is: 8-bit read
//   command, 24-bit address, optional 8 dummy bits, 32 data bits.
//
// Build option:
//   SPI_FETCH_FAST_READ_EN  defined   -> command 0x0B plus 8 dummy bits
//                           undefined -> command 0x03, no dummy phase
//
// Parameters:
//   CLK_DIV         clk cycles per SPI half-period (1..255)
//
// Ports:
//   clk             clock, rising edge
//   rst_n           synchronous active-low reset
//   target_address  flash byte address, captured when a fetch starts
//   start_fetch     level request; held high keeps the result presented
//   fetched_data    fetched word, first flash byte in [7:0]
//   fetch_done      high while the completed word is presented
//   cs              chip select, active-low
//   sclk            SPI clock, idle low
//   mosi            serial data to flash
//   miso            serial data from flash
module spi_fetch_unit #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] target_address,
  input  logic        start_fetch,
  output logic [31:0] fetched_data,
  output logic        fetch_done,
  output logic        cs,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

`ifdef SPI_FETCH_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] addr_q,  addr_d;
  logic [7:0]  div_q,   div_d;    // clk count within the current half-period
  logic        phase_q, phase_d;  // 0: sclk low half, 1: sclk high half
  logic [4:0]  bit_q,   bit_d;    // bit index within the current phase
  logic        lead_q,  lead_d;   // one cs-setup cycle before the first bit
  logic [31:0] rx_q,    rx_d;     // partial receive shift register
  logic [31:0] data_q,  data_d;   // presented word, only written on DONE entry

  logic        active;
  logic [4:0]  bit_last;
  state_e      state_after;

  assign active = (state_q == CMD) || (state_q == ADDR) ||
                  (state_q == DUMMY) || (state_q == DATA);

  // Length and successor of each shifting phase.
  always_comb begin
    bit_last    = 5'd7;
    state_after = IDLE;
    case (state_q)
      CMD: begin
        bit_last    = 5'd7;
        state_after = ADDR;
      end
      ADDR: begin
        bit_last = 5'd23;
`ifdef SPI_FETCH_FAST_READ_EN
        state_after = DUMMY;
`else
        state_after = DATA;
`endif
      end
      DUMMY: begin
        bit_last    = 5'd7;
        state_after = DATA;
      end
      DATA: begin
        bit_last    = 5'd31;
        state_after = DONE;
      end
      default: begin
        bit_last    = 5'd7;
        state_after = IDLE;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    lead_d  = lead_q;
    rx_d    = rx_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (start_fetch) begin
          addr_d  = target_address;
          state_d = CMD;
          lead_d  = 1'b1;
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        if (lead_q) begin
          lead_d = 1'b0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            // This edge raises sclk, so it is also the miso sampling edge.
            phase_d = 1'b1;
            if (state_q == DATA) begin
              rx_d = {rx_q[30:0], miso};
            end
          end else begin
            phase_d = 1'b0;
            if (bit_q == bit_last) begin
              bit_d   = '0;
              state_d = state_after;
              if (state_q == DATA) begin
                // Bytes arrive first-byte-first; the first lands in [7:0].
                data_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
              end
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        if (!start_fetch) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      lead_q  <= 1'b0;
      rx_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      lead_q  <= lead_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
    end
  end

  // Outputs are decoded from registered state only; mosi follows bit_q,
  // which only advances on the edge that drops sclk.
  logic [2:0] cmd_idx;
  logic [4:0] addr_idx;

  assign cmd_idx  = 3'd7 - bit_q[2:0];
  assign addr_idx = 5'd23 - bit_q;

  always_comb begin
    mosi = 1'b0;
    case (state_q)
      CMD:     mosi = READ_CMD[cmd_idx];
      ADDR:    mosi = addr_q[addr_idx];
      default: mosi = 1'b0;
    endcase
  end

  assign cs           = ~active;
  assign sclk         = active & phase_q & ~lead_q;
  assign fetch_done   = (state_q == DONE);
  assign fetched_data = data_q;

endmodule

// File: tb/tb_spi_fetch_unit.sv
module tb_spi_fetch_unit;

  localparam int DIV = 3;
`ifdef SPI_FETCH_FAST_READ_EN
  localparam logic [7:0] EXP_CMD    = 8'h0B;
  localparam int         DATA_START = 40;
`else
  localparam logic [7:0] EXP_CMD    = 8'h03;
  localparam int         DATA_START = 32;
`endif
  localparam int EXP_BITS = DATA_START + 32;
  localparam int EXP_LAT  = 1 + EXP_BITS * 2 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] target_address;
  logic        start_fetch;
  logic [31:0] fetched_data;
  logic        fetch_done;
  logic        cs;
  logic        sclk;
  logic        mosi;
  logic        miso;

  spi_fetch_unit #(.CLK_DIV(DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .target_address (target_address),
    .start_fetch    (start_fetch),
    .fetched_data   (fetched_data),
    .fetch_done     (fetch_done),
    .cs             (cs),
    .sclk           (sclk),
    .mosi           (mosi),
    .miso           (miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- flash model ----------------
  logic [7:0] fbytes [4];
  logic       cap [128];
  int         bitcnt = 0;
  int         viol = 0;
  int         hi_run = 0;
  logic       sclk_p = 1'b0;
  logic       cs_p = 1'b1;
  logic       mosi_p = 1'b0;

  function automatic logic data_bit(input int idx);
    int k;
    if (idx >= DATA_START && idx < DATA_START + 32) begin
      k = idx - DATA_START;
      return fbytes[k / 8][7 - (k % 8)];
    end
    return 1'b0;
  endfunction

  // Samples the bus shortly after each clk edge, away from DUT sampling.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      hi_run = 0;
    end else begin
      if (cs_p && !cs) begin
        bitcnt = 0;
        miso   = 1'b0;
      end
      if (!cs && sclk && !sclk_p) begin
        if (bitcnt < 128) cap[bitcnt] = mosi;
        bitcnt++;
      end
      if (!cs && !sclk && sclk_p) miso = data_bit(bitcnt);
      if (sclk) hi_run++;
      if (!sclk && sclk_p) begin
        if (hi_run != DIV) viol++;
        hi_run = 0;
      end
      if (sclk && sclk_p && mosi !== mosi_p) viol++;
      if (cs && (sclk || mosi)) viol++;
    end
    sclk_p = sclk;
    cs_p   = cs;
    mosi_p = mosi;
  end

  // ---------------- transaction driver (observations only) ----------------
  int          r_lat, r_done_len, r_cs_gap, r_nz, r_nbits;
  logic [31:0] r_data;
  logic        r_data_moved, r_rearm;
  logic [7:0]  r_cmd;
  logic [23:0] r_addr;

  task automatic run_fetch(input logic [23:0] addr, input int drop_at, input int hold_after);
    int e0;
    @(negedge clk);
    target_address = addr;
    start_fetch    = 1'b1;
    @(negedge clk);
    e0 = cyc;
    r_lat = -1;
    r_cs_gap = 0;
    for (int n = 0; n < 4000; n++) begin
      if (fetch_done) begin
        r_lat = cyc - e0;
        break;
      end
      if (cs) r_cs_gap++;
      if (drop_at > 0 && (cyc - e0) >= drop_at) start_fetch = 1'b0;
      target_address = 24'($urandom);
      @(negedge clk);
    end
    r_data = fetched_data;
    r_data_moved = 1'b0;
    r_done_len = (r_lat < 0) ? 0 : 1;
    for (int n = 0; n < 1000 && r_lat >= 0; n++) begin
      if (r_done_len >= hold_after) start_fetch = 1'b0;
      @(negedge clk);
      if (!fetch_done) break;
      r_done_len++;
      if (fetched_data !== r_data) r_data_moved = 1'b1;
    end
    start_fetch = 1'b0;
    r_rearm = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (!cs) r_rearm = 1'b1;
      if (fetched_data !== r_data) r_data_moved = 1'b1;
    end
    r_cmd = '0;
    for (int i = 0; i < 8; i++) r_cmd = {r_cmd[6:0], cap[i]};
    r_addr = '0;
    for (int i = 8; i < 32; i++) r_addr = {r_addr[22:0], cap[i]};
    r_nz = 0;
    for (int i = 32; i < EXP_BITS; i++) if (cap[i]) r_nz++;
    r_nbits = bitcnt;
  endtask

  function automatic logic [31:0] le_word();
    return 32'(fbytes[0]) + (32'(fbytes[1]) << 8) + (32'(fbytes[2]) << 16) + (32'(fbytes[3]) << 24);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start_fetch = 1'b0;
    target_address = '0;
    miso = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL reset_cs: got %b expected 1", cs); end
    vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    vectors++; if (fetch_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", fetch_done); end
    vectors++; if (fetched_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 00000000", fetched_data); end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL idle_no_start_cs: got %b expected 1", cs); end
    end
  endtask

  task automatic test_known_vectors();
    logic [23:0] addrs [2];
    logic [7:0]  bytes [2][4];
    logic [31:0] exps  [2];
    addrs[0] = 24'h000004; bytes[0] = '{8'h13, 8'h00, 8'h00, 8'h00}; exps[0] = 32'h00000013;
    addrs[1] = 24'hABCDEF; bytes[1] = '{8'h78, 8'h56, 8'h34, 8'h12}; exps[1] = 32'h12345678;
    for (int t = 0; t < 2; t++) begin
      fbytes = bytes[t];
      run_fetch(addrs[t], 0, 1);
      vectors++; if (r_data !== exps[t]) begin miscompares++; $display("FAIL known_data[%0d]: got %h expected %h", t, r_data, exps[t]); end
      vectors++; if (r_lat != EXP_LAT) begin miscompares++; $display("FAIL known_latency[%0d]: got %0d expected %0d", t, r_lat, EXP_LAT); end
      vectors++; if (r_cmd !== EXP_CMD) begin miscompares++; $display("FAIL known_cmd[%0d]: got %h expected %h", t, r_cmd, EXP_CMD); end
      vectors++; if (r_addr !== addrs[t]) begin miscompares++; $display("FAIL known_addr[%0d]: got %h expected %h", t, r_addr, addrs[t]); end
      vectors++; if (r_nz != 0) begin miscompares++; $display("FAIL known_mosi_quiet[%0d]: got %0d ones expected 0", t, r_nz); end
      vectors++; if (r_nbits != EXP_BITS) begin miscompares++; $display("FAIL known_sclk_count[%0d]: got %0d expected %0d", t, r_nbits, EXP_BITS); end
      vectors++; if (r_cs_gap != 0) begin miscompares++; $display("FAIL known_cs_low[%0d]: got %0d high cycles expected 0", t, r_cs_gap); end
      vectors++; if (r_done_len != 1) begin miscompares++; $display("FAIL known_done_len[%0d]: got %0d expected 1", t, r_done_len); end
      vectors++; if (r_data_moved !== 1'b0) begin miscompares++; $display("FAIL known_data_hold[%0d]: got %b expected 0", t, r_data_moved); end
    end
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [31:0] exp;
    for (int t = 0; t < 6; t++) begin
      a = 24'($urandom);
      for (int b = 0; b < 4; b++) fbytes[b] = 8'($urandom);
      exp = le_word();
      run_fetch(a, 0, 1);
      vectors++; if (r_data !== exp) begin miscompares++; $display("FAIL random_data[%0d]: got %h expected %h", t, r_data, exp); end
      vectors++; if (r_addr !== a) begin miscompares++; $display("FAIL random_addr[%0d]: got %h expected %h", t, r_addr, a); end
      vectors++; if (r_lat != EXP_LAT) begin miscompares++; $display("FAIL random_latency[%0d]: got %0d expected %0d", t, r_lat, EXP_LAT); end
    end
  endtask

  task automatic test_drop_mid();
    logic [31:0] exp;
    for (int b = 0; b < 4; b++) fbytes[b] = 8'($urandom);
    exp = le_word();
    run_fetch(24'h123456, 40, 1);
    vectors++; if (r_data !== exp) begin miscompares++; $display("FAIL drop_data: got %h expected %h", r_data, exp); end
    vectors++; if (r_lat != EXP_LAT) begin miscompares++; $display("FAIL drop_latency: got %0d expected %0d", r_lat, EXP_LAT); end
    vectors++; if (r_done_len != 1) begin miscompares++; $display("FAIL drop_done_len: got %0d expected 1", r_done_len); end
    vectors++; if (r_rearm !== 1'b0) begin miscompares++; $display("FAIL drop_cs_idle: got %b expected 0", r_rearm); end
    vectors++; if (r_cs_gap != 0) begin miscompares++; $display("FAIL drop_cs_low: got %0d expected 0", r_cs_gap); end
  endtask

  task automatic test_hold_after_done();
    logic [31:0] exp;
    for (int b = 0; b < 4; b++) fbytes[b] = 8'($urandom);
    exp = le_word();
    run_fetch(24'h0F0F0F, 0, 10);
    vectors++; if (r_done_len != 10) begin miscompares++; $display("FAIL hold_done_len: got %0d expected 10", r_done_len); end
    vectors++; if (r_rearm !== 1'b0) begin miscompares++; $display("FAIL hold_second_cs: got %b expected 0", r_rearm); end
    vectors++; if (r_data_moved !== 1'b0) begin miscompares++; $display("FAIL hold_data_stable: got %b expected 0", r_data_moved); end
    vectors++; if (r_data !== exp) begin miscompares++; $display("FAIL hold_data: got %h expected %h", r_data, exp); end
  endtask

  task automatic test_reset_mid();
    int e0;
    logic [31:0] exp;
    logic reached;
    @(negedge clk);
    target_address = 24'h654321;
    start_fetch = 1'b1;
    @(negedge clk);
    e0 = cyc;
    reached = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (cyc - e0 >= 60) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (reached !== 1'b1 || cs !== 1'b0) begin miscompares++; $display("FAIL midreset_inflight_cs: got %b expected 0", cs); end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL midreset_cs: got %b expected 1", cs); end
    vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL midreset_sclk: got %b expected 0", sclk); end
    vectors++; if (fetch_done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b expected 0", fetch_done); end
    vectors++; if (fetched_data !== 32'h0) begin miscompares++; $display("FAIL midreset_data: got %h expected 00000000", fetched_data); end
    start_fetch = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int b = 0; b < 4; b++) fbytes[b] = 8'($urandom);
    exp = le_word();
    run_fetch(24'h00A5C3, 0, 1);
    vectors++; if (r_data !== exp) begin miscompares++; $display("FAIL midreset_refetch_data: got %h expected %h", r_data, exp); end
    vectors++; if (r_addr !== 24'h00A5C3) begin miscompares++; $display("FAIL midreset_refetch_addr: got %h expected 00a5c3", r_addr); end
    vectors++; if (r_cmd !== EXP_CMD) begin miscompares++; $display("FAIL midreset_refetch_cmd: got %h expected %h", r_cmd, EXP_CMD); end
    vectors++; if (r_lat != EXP_LAT) begin miscompares++; $display("FAIL midreset_refetch_latency: got %0d expected %0d", r_lat, EXP_LAT); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int t = 0; t < 3; t++) begin
      for (int b = 0; b < 4; b++) fbytes[b] = 8'($urandom);
      exp = le_word();
      run_fetch(24'($urandom), 0, 1 + t);
      vectors++; if (r_data !== exp) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h expected %h", t, r_data, exp); end
      vectors++; if (r_done_len != 1 + t) begin miscompares++; $display("FAIL b2b_done_len[%0d]: got %0d expected %0d", t, r_done_len, 1 + t); end
    end
  endtask

  task automatic test_protocol();
    vectors++; if (viol != 0) begin miscompares++; $display("FAIL protocol_timing: got %0d violations expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random();
    test_drop_mid();
    test_hold_after_done();
    test_reset_mid();
    test_back_to_back();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
